// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan controller.
// Also hosts the leading-digit helper used when SEG_LZ_BLANK_EN is defined.
package seg_scan_ctrl_pkg;

  localparam int         TICK_DIV_DEFAULT = 50000;
  localparam int         CNT_W_DEFAULT    = 16;
  localparam int         MAX_DIGITS       = 8;
  localparam logic [7:0] ANODE_OFF        = 8'hFF;

  // Position of the most significant non-zero nibble; 0 when the value is all zero.
  function automatic logic [2:0] lead_pos(input logic [31:0] val);
    logic [2:0] pos;
    pos = 3'd0;
    for (int k = 1; k < MAX_DIGITS; k++) begin
      if (val[4*k +: 4] != 4'h0) begin
        pos = 3'(k);
      end else begin
        pos = pos;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bus between a value producer and the scan controller: load strobe/data in,
// per-slot digit information out.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value_in;
  logic [NUM_DIGITS-1:0]     digit_en;
  logic [3:0]                digit_data;
  logic                      digit_ena;
  logic [NUM_DIGITS-1:0]     digit_sel;
  logic                      frame_done;

  modport master (
    output load, value_in, digit_en,
    input  digit_data, digit_ena, digit_sel, frame_done
  );

  modport slave (
    input  load, value_in, digit_en,
    output digit_data, digit_ena, digit_sel, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl_tick_gen.sv
// Slot prescaler: counts 0..TICK_DIV-1 and flags the last count as the slot tick.
module scan_tick_gen #(
  parameter int TICK_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [CNT_W-1:0] cnt_r;
  logic             tick_s;

  assign tick_s = (cnt_r == CNT_W'(TICK_DIV - 1));
  assign tick   = tick_s;

  // Prescaler counter, wraps on the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (tick_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Double-buffered scan controller for an NUM_DIGITS x 7-segment common-anode display.
// Optional leading-zero suppression is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = TICK_DIV_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int VAL_W = 4 * NUM_DIGITS;

  logic                  tick_s;
  logic                  last_s;
  logic                  boundary_s;
  logic [IDX_W-1:0]      idx_r;
  logic [IDX_W-1:0]      idx_nxt_s;
  logic [VAL_W-1:0]      pend_val_r;
  logic [NUM_DIGITS-1:0] pend_mask_r;
  logic                  pend_v_r;
  logic [VAL_W-1:0]      act_val_r;
  logic [VAL_W-1:0]      act_val_nxt_s;
  logic [NUM_DIGITS-1:0] act_mask_r;
  logic [NUM_DIGITS-1:0] act_mask_nxt_s;
  logic                  ena_nxt_s;
  logic [3:0]            digit_data_r;
  logic                  digit_ena_r;
  logic [NUM_DIGITS-1:0] digit_sel_r;
  logic                  frame_done_r;
`ifdef SEG_LZ_BLANK_EN
  logic [2:0]            lz_r;
  logic [2:0]            lz_nxt_s;
`endif

  scan_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_s)
  );

  // Next slot index, next active buffer and the visibility of the next slot.
  always_comb begin
    last_s         = (idx_r == IDX_W'(NUM_DIGITS - 1));
    boundary_s     = tick_s & last_s;
    idx_nxt_s      = idx_r;
    act_val_nxt_s  = act_val_r;
    act_mask_nxt_s = act_mask_r;
    if (tick_s) begin
      idx_nxt_s = last_s ? '0 : idx_r + IDX_W'(1);
    end else begin
      idx_nxt_s = idx_r;
    end
    // A load coinciding with the boundary wins over anything still pending.
    if (boundary_s && bus.load) begin
      act_val_nxt_s  = bus.value_in;
      act_mask_nxt_s = bus.digit_en;
    end else if (boundary_s && pend_v_r) begin
      act_val_nxt_s  = pend_val_r;
      act_mask_nxt_s = pend_mask_r;
    end else begin
      act_val_nxt_s  = act_val_r;
      act_mask_nxt_s = act_mask_r;
    end
    ena_nxt_s = act_mask_nxt_s[idx_nxt_s];
`ifdef SEG_LZ_BLANK_EN
    if (boundary_s && (bus.load || pend_v_r)) begin
      lz_nxt_s = lead_pos(32'(act_val_nxt_s));
    end else begin
      lz_nxt_s = lz_r;
    end
    ena_nxt_s = ena_nxt_s & (int'(idx_nxt_s) <= int'(lz_nxt_s));
`endif
  end

  // Buffers, slot index and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r        <= '0;
      pend_val_r   <= '0;
      pend_mask_r  <= '0;
      pend_v_r     <= 1'b0;
      act_val_r    <= '0;
      act_mask_r   <= '1;
      digit_data_r <= 4'h0;
      digit_ena_r  <= 1'b0;
      digit_sel_r  <= ANODE_OFF[NUM_DIGITS-1:0];
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= boundary_s;
      act_val_r    <= act_val_nxt_s;
      act_mask_r   <= act_mask_nxt_s;
      idx_r        <= idx_nxt_s;
      if (boundary_s) begin
        pend_v_r <= 1'b0;
      end else if (bus.load) begin
        pend_val_r  <= bus.value_in;
        pend_mask_r <= bus.digit_en;
        pend_v_r    <= 1'b1;
      end else begin
        pend_v_r <= pend_v_r;
      end
      if (tick_s) begin
        digit_data_r <= act_val_nxt_s[4*idx_nxt_s +: 4];
        digit_ena_r  <= ena_nxt_s;
        digit_sel_r  <= ena_nxt_s ? ~(NUM_DIGITS'(1) << idx_nxt_s)
                                  : ANODE_OFF[NUM_DIGITS-1:0];
      end else begin
        digit_data_r <= digit_data_r;
        digit_ena_r  <= digit_ena_r;
        digit_sel_r  <= digit_sel_r;
      end
    end
  end

`ifdef SEG_LZ_BLANK_EN
  // Leading-digit position, refreshed only when the active buffer is reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lz_r <= 3'd0;
    end else begin
      lz_r <= lz_nxt_s;
    end
  end
`endif

  assign bus.digit_data = digit_data_r;
  assign bus.digit_ena  = digit_ena_r;
  assign bus.digit_sel  = digit_sel_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (NUM_DIGITS=8, TICK_DIV=4); honours SEG_LZ_BLANK_EN.
module tb_seg_scan_ctrl;
  import seg_scan_ctrl_pkg::*;

  localparam int ND = 8;
  localparam int TD = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    data;
    logic          ena;
    logic [ND-1:0] sel;
    logic          fd;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int fd_seen = 0;

  // Reference model: frame-level view of the display
  int            m_cnt, m_idx;
  logic [3:0]    m_act[ND];
  logic [3:0]    m_pend[ND];
  logic [ND-1:0] m_mask, m_pmask;
  bit            m_pv;
  exp_t          m_out;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    m_cnt = 0; m_idx = 0; m_pv = 1'b0;
    m_mask = '1; m_pmask = '0;
    for (int k = 0; k < ND; k++) begin m_act[k] = 4'h0; m_pend[k] = 4'h0; end
    m_out.data = 4'h0; m_out.ena = 1'b0; m_out.sel = '1; m_out.fd = 1'b0;
  endfunction

  function automatic bit visible(int k);
    if (!m_mask[k]) return 1'b0;
`ifdef SEG_LZ_BLANK_EN
    if (k == 0) return 1'b1;
    for (int j = k; j < ND; j++) if (m_act[j] != 4'h0) return 1'b1;
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic void model_edge(bit ld, logic [31:0] v, logic [ND-1:0] en);
    bit tick;
    tick = (m_cnt == TD - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    m_out.fd = 1'b0;
    if (tick && m_idx == ND - 1) begin
      if (ld) begin
        for (int k = 0; k < ND; k++) m_act[k] = v[4*k +: 4];
        m_mask = en;
      end else if (m_pv) begin
        m_act = m_pend;
        m_mask = m_pmask;
      end
      m_pv = 1'b0;
      m_out.fd = 1'b1;
      m_idx = 0;
    end else begin
      if (ld) begin
        for (int k = 0; k < ND; k++) m_pend[k] = v[4*k +: 4];
        m_pmask = en;
        m_pv = 1'b1;
      end
      if (tick) m_idx = m_idx + 1;
    end
    if (tick) begin
      m_out.ena = visible(m_idx);
      m_out.data = m_act[m_idx];
      m_out.sel = m_out.ena ? ~(ND'(1) << m_idx) : '1;
    end
  endfunction

  // Called at a negedge; drives inputs for one edge and returns at the next negedge.
  task automatic step(bit ld, logic [31:0] v, logic [ND-1:0] en);
    bus.load = ld; bus.value_in = v; bus.digit_en = en;
    @(posedge clk);
    model_edge(ld, v, en);
    q.push_back(m_out);
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic idle_until(int idx);
    int n = 0;
    while (m_idx != idx && n < 100) begin step(1'b0, $urandom, ND'($urandom)); n++; end
    check("idx_reach", 32'(m_idx), 32'(idx));
  endtask

  // Wait for the next frame start, then gather one whole frame from the anodes.
  task automatic collect_frame(output logic [31:0] got, output int vis);
    int n = 0;
    int ena_cycles = 0;
    got = '0;
    while (!m_out.fd && n < 64) begin step(1'b0, $urandom, ND'($urandom)); n++; end
    check("frame_wait", 32'(m_out.fd), 32'd1);
    for (int c = 0; c < ND * TD; c++) begin
      if (c > 0) step(1'b0, $urandom, ND'($urandom));
      for (int k = 0; k < ND; k++)
        if (bus.digit_sel[k] == 1'b0) got[4*k +: 4] = bus.digit_data;
      if (bus.digit_ena) ena_cycles++;
    end
    vis = ena_cycles / TD;
  endtask

  // Monitor: pops the expected response for each edge and compares.
  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("digit_data", 32'(bus.digit_data), 32'(e.data));
      check("digit_ena", 32'(bus.digit_ena), 32'(e.ena));
      check("digit_sel", 32'(bus.digit_sel), 32'(e.sel));
      check("frame_done", 32'(bus.frame_done), 32'(e.fd));
      if (bus.frame_done) fd_seen++;
    end
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [31:0] got;
    int vis, fd0;
    bus.load = 1'b0; bus.value_in = '0; bus.digit_en = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(bus.digit_data), 32'h0);
    check("rst_ena", 32'(bus.digit_ena), 32'h0);
    check("rst_sel", 32'(bus.digit_sel), 32'hFF);
    check("rst_fd", 32'(bus.frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // First tick lands on the 4th edge after release
    repeat (3) step(1'b0, $urandom, ND'($urandom));
    check("pre_tick_sel", 32'(bus.digit_sel), 32'hFF);
    step(1'b0, $urandom, ND'($urandom));
    check("first_tick_sel", 32'(bus.digit_sel), 32'hFD);
    check("first_tick_data", 32'(bus.digit_data), 32'h0);

    // Load mid-frame; appears only from the next frame
    idle_until(3);
    step(1'b1, 32'h1234_ABCD, 8'hFF);
    collect_frame(got, vis);
    check("frame_1234ABCD", got, 32'h1234_ABCD);
    fd0 = fd_seen;
    repeat (64) step(1'b0, $urandom, ND'($urandom));
    check("fd_per_64", 32'(fd_seen - fd0), 32'd2);

    // Last load in a frame wins
    idle_until(2);
    step(1'b1, 32'h1111_1111, 8'hFF);
    repeat (4) step(1'b0, $urandom, ND'($urandom));
    step(1'b1, 32'h2222_2222, 8'hFF);
    collect_frame(got, vis);
    check("last_load_wins", got, 32'h2222_2222);

    // Partial mask
    step(1'b1, 32'h8765_4321, 8'h0F);
    collect_frame(got, vis);
    check("mask_vis", 32'(vis), 32'd4);
    check("mask_val", got, 32'h0000_4321);

    // Leading zeros
    step(1'b1, 32'h0000_00A0, 8'hFF);
    collect_frame(got, vis);
`ifdef SEG_LZ_BLANK_EN
    check("lz_vis", 32'(vis), 32'd2);
`else
    check("lz_vis", 32'(vis), 32'd8);
`endif
    check("lz_val", got, 32'h0000_00A0);

    // Random loads
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(15) == 0), $urandom, ND'($urandom));

    // Asynchronous reset mid-slot discards a pending load
    step(1'b1, 32'h9876_5432, 8'hFF);
    idle_until(5);
    step(1'b1, 32'h5555_5555, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_data", 32'(bus.digit_data), 32'h0);
    check("arst_ena", 32'(bus.digit_ena), 32'h0);
    check("arst_sel", 32'(bus.digit_sel), 32'hFF);
    check("arst_fd", 32'(bus.frame_done), 32'h0);
    model_reset();
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    collect_frame(got, vis);
    check("post_rst_val", got, 32'h0);
`ifdef SEG_LZ_BLANK_EN
    check("post_rst_vis", 32'(vis), 32'd1);
`else
    check("post_rst_vis", 32'(vis), 32'd8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
